spi_sram_arbiter_ctrl: RTL and testbench

- Sequences serial-SRAM transactions (cmd 0x03 read, cmd 0x02 write, 24-bit address) over a 4-wire SPI link to the external 8 MB SRAM.
- Shares that link between the core's instruction-fetch port and data port.
- Sits between the RISC-V core and the SRAM pins; converts the SRAM's big-endian serial byte order to the core's little-endian words.

---
 rtl/spi_sram_pkg.sv | 27 ++
 rtl/spi_shift_engine.sv | 64 ++++++
 rtl/spi_sram_arbiter_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_spi_sram_arbiter_ctrl.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/spi_sram_pkg.sv
// Shared opcodes, FSM states and requester identifiers for the serial-SRAM controller.
package spi_sram_pkg;

  localparam logic [7:0] SPI_READ_CMD  = 8'h03;
  localparam logic [7:0] SPI_WRITE_CMD = 8'h02;

  typedef enum logic [2:0] {
    IDLE,
    LEAD,
    CMD,
    ADDR,
    RDATA,
    WDATA,
    GAP
  } state_e;

  typedef enum logic {
    INSTR,
    DATA
  } port_e;

  // SRAM streams bytes lowest address first; the core wants that byte in bits [7:0].
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_shift_engine.sv
// Bit-level SPI timing: L/H phase toggle, per-state period counter, TX/RX shift registers.
// SCLK and SI are registered so the SRAM pins never glitch.
module spi_shift_engine (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        run,
  input  logic        clk_state_nxt,
  input  logic        load,
  input  logic [31:0] load_dat,
  input  logic        cnt_clr,
  input  logic        rx_en,
  input  logic        so,
  output logic        per_end,
  output logic [7:0]  cnt,
  output logic [31:0] rx_nxt,
  output logic        sclk,
  output logic        si
);

  logic        ph;
  logic        ph_d;
  logic [31:0] tx;
  logic [31:0] rx;

  // ph=0 is the L half of an SCLK period, ph=1 the H half; the phase rests at L while idle.
  assign ph_d    = run & ~ph;
  assign per_end = run & ph;
  assign rx_nxt  = {rx[30:0], so};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ph   <= 1'b0;
      cnt  <= '0;
      tx   <= '0;
      rx   <= '0;
      sclk <= 1'b0;
      si   <= 1'b0;
    end else begin
      ph   <= ph_d;
      sclk <= clk_state_nxt & ph_d;
      if (start) begin
        cnt <= '0;
        rx  <= '0;
        tx  <= load ? {load_dat[30:0], 1'b0} : '0;
        si  <= load & load_dat[31];
      end else if (per_end) begin
        cnt <= cnt_clr ? '0 : cnt + 8'd1;
        // SI changes only at H->L, so it is stable across the SRAM's rising-edge sample.
        if (load) begin
          tx <= {load_dat[30:0], 1'b0};
          si <= load_dat[31];
        end else begin
          tx <= {tx[30:0], 1'b0};
          si <= tx[31];
        end
        if (rx_en) begin
          rx <= rx_nxt;
        end
      end
    end
  end

endmodule

// File: rtl/spi_sram_arbiter_ctrl.sv
// Arbitrates fetch and data ports onto one serial SRAM and sequences LEAD/CMD/ADDR/DATA/GAP.
// Requests are held until their one-cycle done pulse; round-robin when both are pending.
module spi_sram_arbiter_ctrl
  import spi_sram_pkg::*;
#(
  parameter int ADDR_W      = 23,
  parameter int LEAD_CYCLES = 1,
  parameter int GAP_CYCLES  = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_done,
  output logic              sram_sclk,
  output logic              sram_ce,
  output logic              sram_si,
  input  logic              sram_so,
  output logic              busy
);

  localparam logic [7:0] LEAD_LAST = 8'(LEAD_CYCLES - 1);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);

  state_e            state_q, state_n;
  port_e             port_q, last_grant_q, gnt_port;
  logic              we_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;

  logic        start, load, finish, gnt_we, clk_state_nxt, cnt_clr;
  logic [31:0] load_dat;
  logic [7:0]  cnt, wlast;
  logic        per_end;
  logic [31:0] rx_nxt;
  logic [23:0] addr24;

  assign addr24        = 24'(addr_q);
  assign gnt_we        = (gnt_port == DATA) && d_we;
  assign clk_state_nxt = state_n inside {LEAD, CMD, ADDR, RDATA, WDATA};
  assign cnt_clr       = state_n != state_q;
  assign busy          = state_q != IDLE;

  always_comb begin
    unique case (size_q)
      2'd0:    wlast = 8'd7;
      2'd1:    wlast = 8'd15;
      default: wlast = 8'd31;
    endcase
  end

  always_comb begin
    state_n  = state_q;
    gnt_port = INSTR;
    start    = 1'b0;
    load     = 1'b0;
    load_dat = '0;
    finish   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_req || d_req) begin
          if (i_req && d_req) begin
            gnt_port = (last_grant_q == DATA) ? INSTR : DATA;
          end else begin
            gnt_port = i_req ? INSTR : DATA;
          end
          start = 1'b1;
          if (LEAD_CYCLES == 0) begin
            state_n  = CMD;
            load     = 1'b1;
            load_dat = {gnt_we ? SPI_WRITE_CMD : SPI_READ_CMD, 24'h0};
          end else begin
            state_n = LEAD;
          end
        end
      end
      LEAD: begin
        if (per_end && cnt == LEAD_LAST) begin
          state_n  = CMD;
          load     = 1'b1;
          load_dat = {we_q ? SPI_WRITE_CMD : SPI_READ_CMD, 24'h0};
        end
      end
      CMD: begin
        if (per_end && cnt == 8'd7) begin
          state_n  = ADDR;
          load     = 1'b1;
          load_dat = {addr24, 8'h0};
        end
      end
      ADDR: begin
        if (per_end && cnt == 8'd23) begin
          load = 1'b1;
          if (we_q) begin
            state_n  = WDATA;
            load_dat = bswap32(wdata_q);
          end else begin
            state_n = RDATA;
          end
        end
      end
      RDATA: begin
        if (per_end && cnt == 8'd31) begin
          state_n = GAP;
          load    = 1'b1;
          finish  = 1'b1;
        end
      end
      WDATA: begin
        if (per_end && cnt == wlast) begin
          state_n = GAP;
          load    = 1'b1;
          finish  = 1'b1;
        end
      end
      GAP: begin
        if (per_end && cnt == GAP_LAST) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      port_q       <= INSTR;
      last_grant_q <= DATA;
      we_q         <= 1'b0;
      size_q       <= 2'd0;
      addr_q       <= '0;
      wdata_q      <= '0;
      sram_ce      <= 1'b0;
      i_done       <= 1'b0;
      d_done       <= 1'b0;
      i_rdata      <= '0;
      d_rdata      <= '0;
    end else begin
      state_q <= state_n;
      sram_ce <= clk_state_nxt;
      i_done  <= finish && (port_q == INSTR);
      d_done  <= finish && (port_q == DATA);
      if (start) begin
        port_q       <= gnt_port;
        last_grant_q <= gnt_port;
        we_q         <= gnt_we;
        size_q       <= d_size;
        addr_q       <= (gnt_port == INSTR) ? i_addr : d_addr;
        wdata_q      <= d_wdata;
      end
      // The final MISO bit is merged here so rdata is valid alongside the done pulse.
      if (finish && !we_q) begin
        if (port_q == INSTR) begin
          i_rdata <= bswap32(rx_nxt);
        end else begin
          d_rdata <= bswap32(rx_nxt);
        end
      end
    end
  end

  spi_shift_engine u_shift (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .run           (busy),
    .clk_state_nxt (clk_state_nxt),
    .load          (load),
    .load_dat      (load_dat),
    .cnt_clr       (cnt_clr),
    .rx_en         (state_q == RDATA),
    .so            (sram_so),
    .per_end       (per_end),
    .cnt           (cnt),
    .rx_nxt        (rx_nxt),
    .sclk          (sram_sclk),
    .si            (sram_si)
  );

endmodule

// File: tb/tb_spi_sram_arbiter_ctrl.sv
// Directed bench for spi_sram_arbiter_ctrl with a behavioural serial-SRAM model.
module tb_spi_sram_arbiter_ctrl;

  localparam int LEAD = 1;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        i_req = 1'b0;
  logic [22:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [1:0]  d_size = 2'd0;
  logic [22:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        sram_sclk, sram_ce, sram_si;
  logic        sram_so = 1'b0;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  spi_sram_arbiter_ctrl dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_req    (i_req),
    .i_addr   (i_addr),
    .i_rdata  (i_rdata),
    .i_done   (i_done),
    .d_req    (d_req),
    .d_we     (d_we),
    .d_size   (d_size),
    .d_addr   (d_addr),
    .d_wdata  (d_wdata),
    .d_rdata  (d_rdata),
    .d_done   (d_done),
    .sram_sclk(sram_sclk),
    .sram_ce  (sram_ce),
    .sram_si  (sram_si),
    .sram_so  (sram_so),
    .busy     (busy)
  );

  // Serial SRAM model: skips LEAD dummy bits, then command, 24-bit address, data.
  logic [7:0]  mem [0:4095];
  int          bitn = 0;
  int          obit = 0;
  int          b;
  logic [7:0]  cmd = '0;
  logic [23:0] maddr = '0;
  logic [7:0]  wbyte = '0;
  logic [7:0]  obyte;
  int          sclk_total = 0;
  int          done_seen = 0;

  always @(posedge sram_ce) begin
    bitn = 0;
    obit = 0;
    cmd  = '0;
  end

  always @(posedge sram_sclk) begin
    if (sram_ce) begin
      sclk_total++;
      if (bitn >= LEAD) begin
        b = bitn - LEAD;
        if (b < 8) cmd = {cmd[6:0], sram_si};
        else if (b < 32) maddr = {maddr[22:0], sram_si};
        else if (cmd == 8'h02) begin
          wbyte = {wbyte[6:0], sram_si};
          if (((b - 32) % 8) == 7) mem[maddr[11:0] + 12'((b - 32) / 8)] = wbyte;
        end
      end
      bitn++;
    end
  end

  always @(negedge sram_sclk) begin
    if (sram_ce && cmd == 8'h03 && bitn >= LEAD + 32) begin
      obyte   = mem[maddr[11:0] + 12'(obit / 8)];
      sram_so = obyte[7 - (obit % 8)];
      obit++;
    end
  end

  always @(posedge clk) begin
    if (i_done || d_done) done_seen++;
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (busy) check_val("idle_timeout", 32'd1, 32'd0);
  endtask

  // Issues one request from an idle controller; done cycle counted from the first req cycle.
  task automatic txn(input string tag, input bit is_d, input bit we, input logic [1:0] sz,
                     input logic [22:0] a, input logic [31:0] wd, input int exp_cyc,
                     input bit chk_rd, input logic [31:0] exp_rd);
    int   n;
    logic got;
    wait_idle();
    if (is_d) begin
      d_we = we; d_size = sz; d_addr = a; d_wdata = wd; d_req = 1'b1;
    end else begin
      i_addr = a; i_req = 1'b1;
    end
    n = 0;
    got = 1'b0;
    while (!got && n < 400) begin
      @(negedge clk);
      n++;
      got = is_d ? d_done : i_done;
    end
    check_val({tag, "_done_cycle"}, n, exp_cyc);
    if (chk_rd) check_val({tag, "_rdata"}, is_d ? d_rdata : i_rdata, exp_rd);
    i_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
    check_val({tag, "_pulse_width"}, {31'd0, is_d ? d_done : i_done}, 32'd0);
  endtask

  // Both ports request together; the first grant must be exp_first_d, then the other port.
  task automatic arb_round(input string tag, input bit exp_first_d);
    int n;
    int gap;
    wait_idle();
    i_addr = 23'h100; d_we = 1'b0; d_size = 2'd2; d_addr = 23'h200;
    i_req = 1'b1; d_req = 1'b1;
    n = 0;
    while (!(i_done || d_done) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_first_is_data"}, {31'd0, d_done}, {31'd0, exp_first_d});
    check_val({tag, "_first_done_cycle"}, n, 131);
    if (d_done) d_req = 1'b0;
    else i_req = 1'b0;
    gap = 0;
    while (!sram_ce && gap < 400) begin
      gap++;
      @(negedge clk);
    end
    check_val({tag, "_ce_low_cycles"}, gap, 3);
    n = 0;
    while (!(i_done || d_done) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_val({tag, "_second_is_data"}, {31'd0, d_done}, {31'd0, !exp_first_d});
    i_req = 1'b0;
    d_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int snap;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h100] = 8'h11; mem[12'h101] = 8'h22;
    mem[12'h102] = 8'h33; mem[12'h103] = 8'h44;
    mem[12'h302] = 8'h77;

    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset_pins", {29'd0, sram_sclk, sram_ce, sram_si}, 32'd0);
    check_val("reset_busy_done", {29'd0, busy, i_done, d_done}, 32'd0);
    check_val("reset_i_rdata", i_rdata, 32'd0);
    check_val("reset_d_rdata", d_rdata, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    txn("fetch_100", 1'b0, 1'b0, 2'd0, 23'h100, 32'd0, 131, 1'b1, 32'h44332211);

    txn("word_write", 1'b1, 1'b1, 2'd2, 23'h200, 32'hDEADBEEF, 131, 1'b0, 32'd0);
    check_val("mem_200", {24'd0, mem[12'h200]}, 32'h0000_00EF);
    check_val("mem_203", {24'd0, mem[12'h203]}, 32'h0000_00DE);
    txn("word_read", 1'b1, 1'b0, 2'd2, 23'h200, 32'd0, 131, 1'b1, 32'hDEADBEEF);

    txn("byte_write", 1'b1, 1'b1, 2'd0, 23'h203, 32'h123456A5, 83, 1'b0, 32'd0);
    txn("byte_readback", 1'b1, 1'b0, 2'd2, 23'h200, 32'd0, 131, 1'b1, 32'hA5ADBEEF);

    snap = sclk_total;
    txn("half_write", 1'b1, 1'b1, 2'd1, 23'h300, 32'h0000BEEF, 99, 1'b0, 32'd0);
    check_val("half_sclk_periods", sclk_total - snap, 49);
    check_val("mem_300", {24'd0, mem[12'h300]}, 32'h0000_00EF);
    check_val("mem_301", {24'd0, mem[12'h301]}, 32'h0000_00BE);
    check_val("mem_302", {24'd0, mem[12'h302]}, 32'h0000_0077);

    arb_round("arb1", 1'b0);
    arb_round("arb2", 1'b0);
    arb_round("arb3", 1'b0);
    txn("solo_fetch", 1'b0, 1'b0, 2'd0, 23'h100, 32'd0, 131, 1'b1, 32'h44332211);
    arb_round("arb_after_instr", 1'b1);

    wait_idle();
    i_addr = 23'h100;
    i_req = 1'b1;
    repeat (40) @(negedge clk);
    check_val("pre_reset_ce", {31'd0, sram_ce}, 32'd1);
    snap = done_seen;
    #1 reset_n = 1'b0;
    #1;
    check_val("midreset_pins", {29'd0, sram_sclk, sram_ce, sram_si}, 32'd0);
    check_val("midreset_busy", {31'd0, busy}, 32'd0);
    i_req = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check_val("midreset_no_done", done_seen - snap, 0);
    txn("fetch_after_reset", 1'b0, 1'b0, 2'd0, 23'h100, 32'd0, 131, 1'b1, 32'h44332211);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
